// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word type, boot address,
// write-side FSM states and the instruction FIFO entry layout.
`ifndef BOOT_ADDRESS
`define BOOT_ADDRESS 32'h0000_1000
`endif

package instruction_fetch_unit_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word;

  // RUN: every response is kept. DRAIN: wrong-path responses are still in flight.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word addr;
    word data;
  } instr_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop/clear and an occupancy count.
// Used both as the in-flight address queue and as the decoded-instruction buffer.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CW'(DEPTH));
  assign pop_en  = pop && (count != '0);
  assign push_en = push && (!full || pop_en);

  // Empty FIFO presents zero so the head outputs are defined without resetting storage.
  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

  // Storage write.
  // NOTE: the data array carries no reset; only pointers and count do, and rdata is gated by count.
  always_ff @(posedge clock) begin
    if (push_en && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; clear wins over any push or pop in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues in-order reads for the PC address stream,
// pairs returned words with their addresses and buffers them for decode.
// After a taken jump, responses still in flight are counted off and dropped.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  word  fetch_addr,
  output logic fetch_advance,
  input  logic flush,
  output logic mem_req_valid,
  input  logic mem_req_ready,
  output word  mem_req_addr,
  input  logic mem_resp_valid,
  input  word  mem_resp_data,
  output logic instr_valid,
  input  logic instr_ready,
  output word  instr_data,
  output word  instr_addr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  cnt_t         outstanding;
  cnt_t         fifo_count;
  cnt_t         discard;
  cnt_t         discard_next;
  cnt_t         pending;
  logic [CW:0]  in_use;
  logic         credit;
  logic         issue;
  logic         resp_keep;
  logic         resp_drop;
  logic         resp_any;
  logic         aq_full;
  logic         instr_full;
  word          aq_head;
  instr_entry_t new_entry;
  instr_entry_t head_entry;
  fetch_state_t state;
  fetch_state_t state_next;

  // Every slot is either in flight, buffered, or still owed to a wrong-path response.
  assign in_use = {1'b0, outstanding} + {1'b0, fifo_count} + {1'b0, discard};
  assign credit = (in_use < (CW+1)'(DEPTH));

  // Reset gates the request so it reads 0 while reset is held.
  assign mem_req_valid = credit && !flush && !reset;
  assign fetch_advance = mem_req_valid && mem_req_ready;
  assign mem_req_addr  = fetch_addr;
  assign issue         = fetch_advance;

  // A flush-cycle response belongs to the old path and is folded into the new discard count.
  assign resp_drop = mem_resp_valid && !flush && (state == DRAIN);
  assign resp_keep = mem_resp_valid && !flush && (state == RUN) && (outstanding != '0);
  assign pending   = discard + outstanding;
  assign resp_any  = mem_resp_valid && (pending != '0);

  assign new_entry = '{addr: aq_head, data: mem_resp_data};

  assign instr_valid = (fifo_count != '0);
  assign instr_data  = head_entry.data;
  assign instr_addr  = head_entry.addr;

  // Addresses of accepted requests, waiting for their responses.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(word))
  ) u_addr_queue (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .push  (issue),
    .pop   (resp_keep),
    .wdata (fetch_addr),
    .rdata (aq_head),
    .count (outstanding),
    .full  (aq_full)
  );

  // Completed {addr, data} pairs for the decode stage.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(instr_entry_t))
  ) u_instr_fifo (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .push  (resp_keep),
    .pop   (instr_valid && instr_ready),
    .wdata (new_entry),
    .rdata (head_entry),
    .count (fifo_count),
    .full  (instr_full)
  );

  // Next discard count: a flush takes over everything still owed, less a same-cycle response.
  // NOTE: the default assignment first keeps this combinational block free of latches.
  always_comb begin
    discard_next = discard;
    if (flush) begin
      discard_next = pending - cnt_t'(resp_any);
    end else if (resp_drop) begin
      discard_next = discard - cnt_t'(1);
    end
  end

  // Write-side FSM next state: DRAIN while any wrong-path response is owed.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (discard_next != '0) state_next = DRAIN;
      DRAIN:   if (discard_next == '0) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Discard counter and FSM state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      discard <= '0;
      state   <= RUN;
    end else begin
      discard <= discard_next;
      state   <= state_next;
    end
  end

  // The credit rule guarantees room in both queues whenever they are written.
  assert property (@(posedge clock) disable iff (reset) !(resp_keep && instr_full))
    else $error("instruction FIFO written while full");
  assert property (@(posedge clock) disable iff (reset) !(issue && aq_full))
    else $error("address queue written while full");

endmodule
